motor_dose_sequencer: RTL and testbench

- Sequences the three pigment dosing motors (R, Y, B) once the colour amounts have been entered.
- Runs each motor for a time proportional to its amount, in fixed order R -> Y -> B, never more than one motor at a time.
- Inserts a dead time between consecutive motors.
- Produces the per-colour completion flags consumed by the main machine FSM. It replaces the external flag_R/flag_G/flag_B sources.

---
 rtl/motor_dose_sequencer.sv | 140 ++++++++++++++
 tb/tb_motor_dose_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/motor_dose_sequencer.sv
// rtl/motor_dose_sequencer.sv - runs the R, Y, B pigment motors in turn with dead time and completion flags
module motor_dose_sequencer #(
  parameter int AMT_W       = 5,
  parameter int UNIT_CYCLES = 50000000,
  parameter int DEAD_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [AMT_W-1:0] amount_r,
  input  logic [AMT_W-1:0] amount_y,
  input  logic [AMT_W-1:0] amount_b,
  output logic [2:0]       motor,
  output logic             flag_r,
  output logic             flag_y,
  output logic             flag_b,
  output logic             busy,
  output logic             done,
  output logic [AMT_W-1:0] remaining
);

  localparam int UNIT_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(UNIT_CYCLES - 1);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RUN_R   = 3'd1;
  localparam logic [2:0] S_DEAD_RY = 3'd2;
  localparam logic [2:0] S_RUN_Y   = 3'd3;
  localparam logic [2:0] S_DEAD_YB = 3'd4;
  localparam logic [2:0] S_RUN_B   = 3'd5;
  localparam logic [2:0] S_FINISH  = 3'd6;

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic [AMT_W-1:0] r_lat_r, r_lat_y, r_lat_b;
  logic [AMT_W-1:0] w_amt_r, w_amt_y, w_amt_b;
  logic [AMT_W-1:0] w_entry_amt;
  logic [UNIT_W-1:0] r_unit_cnt;
  logic [DEAD_W-1:0] r_dead_cnt;
  logic             w_unit_wrap;
  logic             w_dead_end;
  logic             w_run_last;
  logic             w_next_run;
  logic             w_next_dead;
  logic             w_stay;

  // Amount sources, counter terminal conditions and next-state selection
  always_comb begin
    // In IDLE the latches are not loaded yet, so the start decision looks at the live inputs
    w_amt_r     = (r_state == S_IDLE) ? amount_r : r_lat_r;
    w_amt_y     = (r_state == S_IDLE) ? amount_y : r_lat_y;
    w_amt_b     = (r_state == S_IDLE) ? amount_b : r_lat_b;
    w_unit_wrap = (r_unit_cnt == UNIT_LAST);
    w_dead_end  = (r_dead_cnt == DEAD_LAST);
    w_run_last  = w_unit_wrap && (remaining == AMT_W'(1));
    w_next      = r_state;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          if (w_amt_r != '0)      w_next = S_RUN_R;
          else if (w_amt_y != '0) w_next = S_RUN_Y;
          else if (w_amt_b != '0) w_next = S_RUN_B;
          else                    w_next = S_FINISH;
        end
      end
      S_RUN_R:   if (w_run_last) w_next = ((w_amt_y != '0) || (w_amt_b != '0)) ? S_DEAD_RY : S_FINISH;
      S_DEAD_RY: if (w_dead_end) w_next = (w_amt_y != '0) ? S_RUN_Y : S_RUN_B;
      S_RUN_Y:   if (w_run_last) w_next = (w_amt_b != '0) ? S_DEAD_YB : S_FINISH;
      S_DEAD_YB: if (w_dead_end) w_next = S_RUN_B;
      S_RUN_B:   if (w_run_last) w_next = S_FINISH;
      S_FINISH:  w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
    if (abort && (r_state != S_IDLE)) w_next = S_IDLE;
    w_next_run  = (w_next == S_RUN_R) || (w_next == S_RUN_Y) || (w_next == S_RUN_B);
    w_next_dead = (w_next == S_DEAD_RY) || (w_next == S_DEAD_YB);
    w_stay      = (w_next == r_state);
    case (w_next)
      S_RUN_R: w_entry_amt = w_amt_r;
      S_RUN_Y: w_entry_amt = w_amt_y;
      default: w_entry_amt = w_amt_b;
    endcase
  end

  // State register and amount latches captured when a cycle is accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_lat_r <= '0;
      r_lat_y <= '0;
      r_lat_b <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_next != S_IDLE) begin
        r_lat_r <= amount_r;
        r_lat_y <= amount_y;
        r_lat_b <= amount_b;
      end
    end
  end

  // Unit and dead-time counters restart on every state entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_unit_cnt <= '0;
      r_dead_cnt <= '0;
    end else begin
      r_unit_cnt <= (w_next_run && w_stay) ? (w_unit_wrap ? '0 : r_unit_cnt + UNIT_W'(1)) : '0;
      r_dead_cnt <= (w_next_dead && w_stay) ? r_dead_cnt + DEAD_W'(1) : '0;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      motor     <= 3'b000;
      flag_r    <= 1'b0;
      flag_y    <= 1'b0;
      flag_b    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
    end else begin
      motor     <= {w_next == S_RUN_R, w_next == S_RUN_Y, w_next == S_RUN_B};
      // Leaving a RUN state without abort can only mean its last unit completed
      flag_r    <= (r_state == S_RUN_R) && (w_next != S_RUN_R) && !abort;
      flag_y    <= (r_state == S_RUN_Y) && (w_next != S_RUN_Y) && !abort;
      flag_b    <= (r_state == S_RUN_B) && (w_next != S_RUN_B) && !abort;
      busy      <= (w_next != S_IDLE);
      done      <= (w_next == S_FINISH);
      if (!w_next_run)       remaining <= '0;
      else if (!w_stay)      remaining <= w_entry_amt;
      else if (w_unit_wrap)  remaining <= remaining - AMT_W'(1);
    end
  end

endmodule

// File: tb/tb_motor_dose_sequencer.sv
// tb/tb_motor_dose_sequencer.sv - scoreboard bench for the dose sequencer
module tb_motor_dose_sequencer;
  localparam int AMT_W = 5;
  localparam int UNIT  = 4;
  localparam int DEAD  = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             abort;
  logic [AMT_W-1:0] amount_r, amount_y, amount_b;
  logic [2:0]       motor;
  logic             flag_r, flag_y, flag_b, busy, done;
  logic [AMT_W-1:0] remaining;
  logic [12:0]      obs;
  logic [12:0]      exp_q[$];
  int               n_assert = 0;
  int               n_fail = 0;

  motor_dose_sequencer #(.AMT_W(AMT_W), .UNIT_CYCLES(UNIT), .DEAD_CYCLES(DEAD)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .amount_r(amount_r), .amount_y(amount_y), .amount_b(amount_b),
    .motor(motor), .flag_r(flag_r), .flag_y(flag_y), .flag_b(flag_b),
    .busy(busy), .done(done), .remaining(remaining)
  );

  always #5 clk = ~clk;

  assign obs = {motor, flag_r, flag_y, flag_b, busy, done, remaining};

  task automatic check(input string tag, input logic [12:0] expv, input logic [12:0] got);
    n_assert++;
    assert (got === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, got, expv);
    end
  endtask

  task automatic push(input logic [2:0] m, input logic [2:0] f, input logic b, input logic d,
                      input int rem);
    exp_q.push_back({m, f, b, d, 5'(rem)});
  endtask

  // Reference trace for cycles 1.. after acceptance, ending with one idle cycle
  task automatic gen_trace(input int ar, input int ay, input int ab);
    int amts[3];
    logic [2:0] bits[3];
    int order[$];
    logic [2:0] pend;
    amts[0] = ar; amts[1] = ay; amts[2] = ab;
    bits[0] = 3'b100; bits[1] = 3'b010; bits[2] = 3'b001;
    pend = 3'b000;
    for (int i = 0; i < 3; i++) if (amts[i] != 0) order.push_back(i);
    for (int k = 0; k < order.size(); k++) begin
      if (k > 0) begin
        for (int d = 0; d < DEAD; d++) push(3'b000, (d == 0) ? pend : 3'b000, 1'b1, 1'b0, 0);
      end
      for (int u = amts[order[k]]; u >= 1; u--)
        for (int c = 0; c < UNIT; c++) push(bits[order[k]], 3'b000, 1'b1, 1'b0, u);
      pend = bits[order[k]];
    end
    push(3'b000, pend, 1'b1, 1'b1, 0);
    push(3'b000, 3'b000, 1'b0, 1'b0, 0);
  endtask

  // Drives start during cycle 0; returns inside cycle 1
  task automatic begin_cycle(input int ar, input int ay, input int ab);
    amount_r = 5'(ar); amount_y = 5'(ay); amount_b = 5'(ab);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic consume(input string tag, input int abort_at, input int restart_at);
    int c;
    c = 1;
    while (exp_q.size() > 0) begin
      abort = (c == abort_at);
      start = (c == restart_at);
      if (c == restart_at) amount_r = 5'd7;
      @(negedge clk);
      check($sformatf("%s c%0d", tag, c), exp_q.pop_front(), obs);
      @(posedge clk); #1;
      c++;
    end
    abort = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    amount_r = '0; amount_y = '0; amount_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", 13'b0, obs);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("idle_after_reset", 13'b0, obs);
    @(posedge clk); #1;

    gen_trace(2, 1, 3);
    begin_cycle(2, 1, 3);
    consume("rgb_213", 0, 0);

    gen_trace(0, 0, 0);
    begin_cycle(0, 0, 0);
    consume("all_zero", 0, 0);

    gen_trace(0, 2, 0);
    begin_cycle(0, 2, 0);
    consume("y_only", 0, 0);

    gen_trace(1, 0, 2);
    begin_cycle(1, 0, 2);
    consume("skip_y", 0, 0);

    gen_trace(1, 1, 1);
    while (exp_q.size() > 7) void'(exp_q.pop_back());
    push(3'b000, 3'b000, 1'b0, 1'b0, 0);
    push(3'b000, 3'b000, 1'b0, 1'b0, 0);
    begin_cycle(1, 1, 1);
    consume("abort", 7, 0);

    gen_trace(1, 0, 0);
    begin_cycle(1, 0, 0);
    consume("after_abort", 0, 0);

    amount_r = 5'd1; amount_y = 5'd1; amount_b = 5'd1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("abort_wins c%0d", i + 1), 13'b0, obs);
      @(posedge clk); #1;
    end

    gen_trace(3, 0, 0);
    begin_cycle(3, 0, 0);
    consume("latch_ignore", 0, 3);

    gen_trace(3, 0, 0);
    while (exp_q.size() > 5) void'(exp_q.pop_back());
    begin_cycle(3, 0, 0);
    consume("pre_reset", 0, 0);
    check("pre_reset c6", {3'b100, 3'b000, 1'b1, 1'b0, 5'd2}, obs);
    reset = 1'b1;
    #1;
    check("async_reset", 13'b0, obs);
    @(negedge clk);
    check("reset_hold", 13'b0, obs);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("idle_after_release", 13'b0, obs);
    @(posedge clk); #1;

    gen_trace(0, 0, 1);
    begin_cycle(0, 0, 1);
    consume("b_after_reset", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
